// File: rtl/dest_reg_tracker.sv
// Carries decode destination/RegWrite/MemRead through EX/MEM/WB; yields load-use Stall, EX forwarding selects, WB write port.
// Stall/Fwd are combinational, WB outputs are registered (decode -> WbDst after 3 edges); STALL_CNT_EN adds a saturating stall counter.
module dest_reg_tracker #(
  parameter int REG_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid_ID,
  input  logic [REG_W-1:0] DstReg_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UseRs_ID,
  input  logic             UseRt_ID,
  input  logic             Flush,
  output logic             Stall,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic [REG_W-1:0] WbDst,
  output logic             WbRegWrite
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] StallCount
`endif
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             rw;
    logic             mr;
  } stage_t;

  typedef struct packed {
    stage_t           base;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } ex_t;

  ex_t    ex_q, ex_d;
  stage_t mem_q, wb_q;

  function automatic logic fwd_hit(input stage_t s, input logic [REG_W-1:0] src,
                                   input logic use_src);
    return use_src && s.valid && s.rw && (s.dst != '0) && (s.dst == src);
  endfunction

  // A load in EX with a nonzero destination read by the decode instruction must wait one cycle.
  assign Stall = Valid_ID && !Flush && ex_q.base.valid && ex_q.base.mr && (ex_q.base.dst != '0) &&
                 ((UseRs_ID && (Rs_ID == ex_q.base.dst)) || (UseRt_ID && (Rt_ID == ex_q.base.dst)));

  always_comb begin
    ex_d = '0;
    if (Valid_ID && !Flush && !Stall) begin
      ex_d.base.valid = 1'b1;
      ex_d.base.dst   = DstReg_ID;
      ex_d.base.rw    = RegWrite_ID;
      ex_d.base.mr    = MemRead_ID;
      ex_d.rs         = Rs_ID;
      ex_d.rt         = Rt_ID;
      ex_d.use_rs     = UseRs_ID;
      ex_d.use_rt     = UseRt_ID;
    end
  end

  always_comb begin
    FwdA = 2'b00;
    FwdB = 2'b00;
    if (fwd_hit(mem_q, ex_q.rs, ex_q.use_rs))     FwdA = 2'b01;
    else if (fwd_hit(wb_q, ex_q.rs, ex_q.use_rs)) FwdA = 2'b10;
    if (fwd_hit(mem_q, ex_q.rt, ex_q.use_rt))     FwdB = 2'b01;
    else if (fwd_hit(wb_q, ex_q.rt, ex_q.use_rt)) FwdB = 2'b10;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q.base;
      wb_q  <= mem_q;
    end
  end

  assign WbDst      = wb_q.dst;
  assign WbRegWrite = wb_q.valid & wb_q.rw;

  // MemRead rides along past EX for debug visibility only.
  logic unused_mr;
  assign unused_mr = mem_q.mr ^ wb_q.mr;

`ifdef STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`else
  logic [STALL_CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker: forwarding, load-use stall, register zero, flush, mid-stream reset.
module tb_dest_reg_tracker;
  logic       Clk = 1'b0;
  logic       Rst;
  logic       Valid_ID;
  logic [4:0] DstReg_ID;
  logic       RegWrite_ID;
  logic       MemRead_ID;
  logic [4:0] Rs_ID;
  logic [4:0] Rt_ID;
  logic       UseRs_ID;
  logic       UseRt_ID;
  logic       Flush;
  logic       Stall;
  logic [1:0] FwdA;
  logic [1:0] FwdB;
  logic [4:0] WbDst;
  logic       WbRegWrite;
`ifdef STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  int tests = 0;
  int fails = 0;

  dest_reg_tracker #(.REG_W(5), .STALL_CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Valid_ID(Valid_ID), .DstReg_ID(DstReg_ID),
    .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID), .Flush(Flush), .Stall(Stall),
    .FwdA(FwdA), .FwdB(FwdB), .WbDst(WbDst), .WbRegWrite(WbRegWrite)
`ifdef STALL_CNT_EN
    , .StallCount(StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic drv(input int v, input int dst, input int rw, input int mr, input int rs,
                     input int rt, input int urs, input int urt, input int fl);
    Valid_ID    = (v != 0);
    DstReg_ID   = 5'(dst);
    RegWrite_ID = (rw != 0);
    MemRead_ID  = (mr != 0);
    Rs_ID       = 5'(rs);
    Rt_ID       = 5'(rt);
    UseRs_ID    = (urs != 0);
    UseRt_ID    = (urt != 0);
    Flush       = (fl != 0);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Moves to just after the next falling edge, well clear of the rising edge.
  task automatic nxt();
    @(negedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    tests++;
    assert (obs === 32'(exp))
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    #2;
    chk("rst_stall", 32'(Stall), 0);
    chk("rst_fwda", 32'(FwdA), 0);
    chk("rst_fwdb", 32'(FwdB), 0);
    chk("rst_wbdst", 32'(WbDst), 0);
    chk("rst_wbrw", 32'(WbRegWrite), 0);
    nxt();
    Rst = 1'b0;

    // add $8 ; sub rs=$8 ; or rt=$8
    drv(1, 8, 1, 0, 1, 2, 1, 1, 0);  #1; chk("alu_nostall", 32'(Stall), 0);
    nxt();
    drv(1, 11, 1, 0, 8, 3, 1, 1, 0);
    nxt();
    drv(1, 12, 1, 0, 4, 8, 1, 1, 0); #1;
    chk("alu_fwda_mem", 32'(FwdA), 1);
    chk("alu_fwdb_none", 32'(FwdB), 0);
    nxt();
    idle(); #1;
    chk("alu_fwdb_wb", 32'(FwdB), 2);
    chk("alu_fwda_none", 32'(FwdA), 0);
    chk("lat_wbdst", 32'(WbDst), 8);
    chk("lat_wbrw", 32'(WbRegWrite), 1);
    nxt();

    // lw $9 ; add rt=$9
    drv(1, 9, 1, 1, 2, 0, 1, 0, 0);  #1; chk("lat_wbdst2", 32'(WbDst), 11);
    nxt();
    drv(1, 13, 1, 0, 5, 9, 1, 1, 0); #1; chk("lu_stall1", 32'(Stall), 1);
    nxt();
    drv(1, 13, 1, 0, 5, 9, 1, 1, 0); #1; chk("lu_stall_once", 32'(Stall), 0);
    nxt();
    idle(); #1;
    chk("lu_fwdb_wb", 32'(FwdB), 2);
    chk("lu_fwda", 32'(FwdA), 0);
    chk("lu_wbdst", 32'(WbDst), 9);
    nxt();

    // $10 written twice, then read as rs
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0); nxt();
    drv(1, 10, 1, 0, 0, 0, 0, 0, 0); nxt();
    drv(1, 14, 1, 0, 10, 0, 1, 0, 0); nxt();
    idle(); #1; chk("dbl_fwda_mem", 32'(FwdA), 1);
    nxt();

    // lw $0 then use of $0
    drv(1, 0, 1, 1, 0, 0, 0, 0, 0); nxt();
    drv(1, 15, 1, 0, 0, 0, 1, 1, 0); #1; chk("r0_stall", 32'(Stall), 0);
    nxt();
    idle(); #1;
    chk("r0_fwda", 32'(FwdA), 0);
    chk("r0_fwdb", 32'(FwdB), 0);
    nxt();

    // lw $20 then flushed dependent
    drv(1, 20, 1, 1, 0, 0, 0, 0, 0); #1;
    chk("r0_wbdst", 32'(WbDst), 0);
    chk("r0_wbrw", 32'(WbRegWrite), 1);
    nxt();
    drv(1, 21, 1, 0, 20, 0, 1, 0, 1); #1; chk("fl_stall", 32'(Stall), 0);
    nxt();
    idle(); #1; chk("fl_stall_after", 32'(Stall), 0);
`ifdef STALL_CNT_EN
    chk("fl_cnt", 32'(StallCount), 1);
`endif
    nxt();
    chk("fl_wbdst_load", 32'(WbDst), 20);
    chk("fl_wbrw_load", 32'(WbRegWrite), 1);
    nxt();
    chk("fl_no_wb", 32'(WbRegWrite), 0);

    // three in flight, then asynchronous reset between edges
    drv(1, 1, 1, 0, 0, 0, 0, 0, 0); nxt();
    drv(1, 2, 1, 0, 0, 0, 0, 0, 0); nxt();
    drv(1, 3, 1, 1, 2, 0, 1, 0, 0); nxt();
    drv(1, 4, 1, 0, 0, 3, 0, 1, 0); #1;
    chk("pre_stall", 32'(Stall), 1);
    chk("pre_fwda", 32'(FwdA), 1);
    chk("pre_wbdst", 32'(WbDst), 1);
    chk("pre_wbrw", 32'(WbRegWrite), 1);
    #1;
    Rst = 1'b1;
    #1;
    chk("mid_stall", 32'(Stall), 0);
    chk("mid_fwda", 32'(FwdA), 0);
    chk("mid_fwdb", 32'(FwdB), 0);
    chk("mid_wbdst", 32'(WbDst), 0);
    chk("mid_wbrw", 32'(WbRegWrite), 0);
`ifdef STALL_CNT_EN
    chk("mid_cnt", 32'(StallCount), 0);
`endif
    idle();
    nxt();
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("post_rst_wbrw", 32'(WbRegWrite), 0);
    end

`ifdef STALL_CNT_EN
    for (int i = 0; i < 5; i++) begin
      drv(1, 9, 1, 1, 0, 0, 0, 0, 0); nxt();
      drv(1, 13, 1, 0, 9, 0, 1, 0, 0); #1; chk("cnt_stall", 32'(Stall), 1);
      nxt();
      idle(); nxt();
    end
    chk("cnt_five", 32'(StallCount), 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
- Consumes the 5-bit destination-register number produced by the decode-stage write-register select mux (rt / rd / $31 / alternate), plus the decode-stage control bits.
- Carries the destination, RegWrite and MemRead through the EX, MEM and WB stages.
- Produces a combinational load-use stall, 2-bit forwarding selects for the EX-stage ALU operand muxes, and the WB-stage register-file write address and enable.
- Sits between the decode-stage destination mux and the EX operand muxes and register file.

Parameters:
- REG_W, 5, register-address width.
- STALL_CNT_W, 16, stall-counter width; used only with the optional feature.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Valid_ID  input  1  decode stage holds a real instruction.
- DstReg_ID  input  REG_W  destination register from the destination mux.
- RegWrite_ID  input  1  instruction in decode writes a register.
- MemRead_ID  input  1  instruction in decode is a load.
- Rs_ID  input  REG_W  decode source register A.
- Rt_ID  input  REG_W  decode source register B.
- UseRs_ID  input  1  instruction reads Rs.
- UseRt_ID  input  1  instruction reads Rt.
- Flush  input  1  branch/jump taken; kill the decode instruction.
- Stall  output  1  load-use hazard; upstream holds PC and IF/ID.
- FwdA  output  2  EX operand-A select.
- FwdB  output  2  EX operand-B select.
- WbDst  output  REG_W  register-file write address.
- WbRegWrite  output  1  register-file write enable.
- StallCount  output  STALL_CNT_W  present only with STALL_CNT_EN.

Behaviour:
- State:
  - Three stage registers EX, MEM, WB. Each holds {valid, dst, rw, mr}.
  - EX additionally holds {rs, rt, use_rs, use_rt}.
- Reset:
  - Rst high clears every field to 0 asynchronously, including mid-operation.
  - While Rst is high: Stall=0, FwdA=FwdB=2'b00, WbDst=0, WbRegWrite=0, StallCount=0.
  - First instruction accepted on the first rising edge after Rst deasserts.
- Advance, every rising edge:
  - WB <= MEM.
  - MEM <= EX.
  - If Flush or Stall or !Valid_ID: EX <= bubble (all fields 0). Flush has priority over everything.
  - Else EX <= {1, DstReg_ID, RegWrite_ID, MemRead_ID, Rs_ID, Rt_ID, UseRs_ID, UseRt_ID}.
- Stall (combinational, same cycle):
  - Stall = Valid_ID & !Flush & EX.valid & EX.mr & (EX.dst != 0) & ((UseRs_ID & Rs_ID == EX.dst) | (UseRt_ID & Rt_ID == EX.dst)).
  - Exactly one stall cycle per load-use pair; the load is in WB when the dependent instruction enters EX.
- Forwarding (combinational), FwdA shown; FwdB is identical using rt/use_rt:
  - 2'b01 if EX.use_rs & MEM.rw & MEM.valid & MEM.dst != 0 & MEM.dst == EX.rs.
  - Else 2'b10 if the same condition holds for WB.
  - Else 2'b00 (register file).
  - MEM wins over WB when both match.
  - 2'b11 is never driven.
- Writeback:
  - WbDst = WB.dst; WbRegWrite = WB.rw & WB.valid. Both come directly from registers, with no combinational path.
- Register 0:
  - Never forwarded and never causes a stall.
  - A write to register 0 still appears on WbRegWrite; the register file ignores it.
- Flush and Stall in the same cycle: Flush wins, EX gets a bubble, and Stall is forced to 0.
- Latency: DstReg_ID accepted at edge N appears on WbDst after edge N+2. Writeback is 3 cycles after decode.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - StallCount port exists.
  - Increments by 1 on each rising edge where Stall=1.
  - Saturates at all-ones.
  - Cleared by Rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-stream: three instructions in flight, assert Rst between edges -> all outputs 0 immediately. After release, WbRegWrite stays 0 for 3 edges with Valid_ID=0.
- Back-to-back ALU dependency: add $8 then sub using Rs=$8 -> on the sub's EX cycle FwdA=01. Next instruction using $8 as Rt -> FwdB=10.
- Load-use: lw $9 then add Rt=$9 -> Stall=1 for exactly one cycle. The add's EX cycle shows FwdB=10, and Stall returns to 0.
- Double match: $10 written in both MEM and WB, EX reads Rs=$10 -> FwdA=01 (MEM priority).
- Register zero: lw $0 followed by use of $0 -> Stall=0 and FwdA=FwdB=00. Three cycles later WbDst=0, WbRegWrite=1.
- Flush with stall: load-use condition with Flush=1 -> Stall=0, EX bubble, and no writeback 2 edges later. With STALL_CNT_EN, StallCount is unchanged; after 5 true stalls it reads 5.
